reservation_station_ooo: RTL and testbench

- Next-generation reservation station for the fcpu out-of-order core. It sits between dispatch and one functional unit.
- Holds up to 2**N_ENTRIES_W instructions and snoops N_CDB common-data-bus ports per cycle, including a same-cycle snoop on the dispatched entry.
- Issues the oldest ready entry, or strictly in order when IN_ORDER=1.
- Supports a pipeline flush and reports occupancy.

---
 rtl/reservation_station_ooo_pkg.sv | 49 ++++
 rtl/reservation_station_ooo_age_matrix.sv | 49 ++++
 rtl/reservation_station_ooo.sv | 171 +++++++++++++++++
 tb/tb_reservation_station_ooo.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_ooo_pkg.sv
// reservation_station_ooo_pkg: shared widths, entry/CDB types and the CDB tag-match helper.
// Rev 1.0
`default_nettype none

package reservation_station_ooo_pkg;

  localparam int RSV_ID_W = 4;
  localparam int INSTR_W  = 8;
  localparam int DATA_W   = 8;
  localparam int CDB_W    = RSV_ID_W + DATA_W;
  localparam int OPS_MAX  = 3;
  localparam int CDB_MAX  = 4;

  typedef struct packed {
    logic [RSV_ID_W-1:0] tag;
    logic [DATA_W-1:0]   data;
  } cdb_t;

  typedef struct packed {
    logic                       valid;
    logic [RSV_ID_W-1:0]        dest;
    logic [INSTR_W-1:0]         opcode;
    logic [OPS_MAX-1:0]         filled;
    cdb_t [OPS_MAX-1:0]         opnd;
  } rsv_entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } cdb_hit_t;

  // Walks ports from high to low so the lowest matching port index wins.
  function automatic cdb_hit_t cdb_match(input logic [RSV_ID_W-1:0] tag,
                                         input logic [CDB_MAX-1:0]  vld,
                                         input cdb_t [CDB_MAX-1:0]  bus);
    cdb_hit_t r;
    r = '0;
    for (int p = CDB_MAX - 1; p >= 0; p--) begin
      if (vld[p] && (bus[p].tag == tag)) begin
        r.hit  = 1'b1;
        r.data = bus[p].data;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reservation_station_ooo_age_matrix.sv
// reservation_station_ooo_age_matrix: pairwise age matrix returning the oldest requester.
// Rev 1.0
`default_nettype none

module reservation_station_ooo_age_matrix #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [N-1:0] i_alloc,
  input  logic [N-1:0] i_free,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  // r_older[i][j] = 1 when entry i is older than entry j; diagonal stays 0.
  logic [N-1:0] r_older [N];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < N; i++) r_older[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i_free[i] || i_free[j]) begin
            r_older[i][j] <= 1'b0;
          end else if (i_alloc[j] && (i != j)) begin
            r_older[i][j] <= 1'b1;
          end else if (i_alloc[i]) begin
            r_older[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = i_req[i];
      for (int j = 0; j < N; j++) begin
        if (i_req[j] && r_older[j][i]) o_grant[i] = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reservation_station_ooo.sv
// reservation_station_ooo: CDB-snooping reservation station issuing the oldest ready entry.
// Rev 1.0
`default_nettype none

module reservation_station_ooo
  import reservation_station_ooo_pkg::*;
#(
  parameter int N_OPERANDS  = 2,
  parameter int N_ENTRIES_W = 3,
  parameter int N_CDB       = 2,
  parameter int IN_ORDER    = 0
) (
  input  logic                                                    clk,
  input  logic                                                    nrst,
  input  logic                                                    i_valid,
  input  logic [RSV_ID_W+INSTR_W+N_OPERANDS*(RSV_ID_W+DATA_W)-1:0] i_data,
  input  logic [N_OPERANDS-1:0]                                   i_filled,
  output logic                                                    i_ready,
  output logic                                                    o_valid,
  output logic [RSV_ID_W+INSTR_W+N_OPERANDS*DATA_W-1:0]            o_data,
  input  logic                                                    o_ready,
  input  logic [N_CDB-1:0]                                        cdb_valid,
  input  logic [N_CDB*CDB_W-1:0]                                  cdb,
  input  logic                                                    flush,
  output logic [N_ENTRIES_W:0]                                    o_count
);

  localparam int NE   = 1 << N_ENTRIES_W;
  localparam int OP_W = RSV_ID_W + DATA_W;
  localparam int IN_W = RSV_ID_W + INSTR_W + N_OPERANDS * OP_W;

  rsv_entry_t r_ent     [NE];
  rsv_entry_t w_ent_nxt [NE];
  rsv_entry_t w_new;

  logic [N_ENTRIES_W:0] r_count;
  logic                 r_lock;
  logic [NE-1:0]        r_lock_oh;

  logic [NE-1:0] w_valid, w_rdy, w_req, w_grant, w_sel;
  logic [NE-1:0] w_alloc_oh, w_issue_oh, w_age_alloc, w_age_free;
  logic          w_full, w_accept, w_issue, w_found, w_unused;

  cdb_t [CDB_MAX-1:0]     w_cdb;
  logic [CDB_MAX-1:0]     w_cdb_vld;

  logic [RSV_ID_W-1:0]          w_sel_dest;
  logic [INSTR_W-1:0]           w_sel_opc;
  logic [N_OPERANDS*DATA_W-1:0] w_sel_ops;

  for (genvar p = 0; p < CDB_MAX; p++) begin : g_cdb
    if (p < N_CDB) begin : g_used
      assign w_cdb[p]     = cdb_t'(cdb[p*CDB_W +: CDB_W]);
      assign w_cdb_vld[p] = cdb_valid[p];
    end else begin : g_pad
      assign w_cdb[p]     = '0;
      assign w_cdb_vld[p] = 1'b0;
    end
  end

  for (genvar e = 0; e < NE; e++) begin : g_status
    assign w_valid[e] = r_ent[e].valid;
    assign w_rdy[e]   = r_ent[e].valid & (&r_ent[e].filled);
  end

  assign w_full   = &w_valid;
  assign i_ready  = ~w_full;
  assign w_accept = i_valid & ~w_full & ~flush;
  assign w_req    = (IN_ORDER != 0) ? w_valid : w_rdy;

  // A presented-but-stalled entry stays locked so o_data cannot change under the FU.
  assign w_sel      = r_lock ? r_lock_oh : (w_grant & w_rdy);
  assign o_valid    = |w_sel;
  assign w_issue    = o_valid & o_ready;
  assign w_issue_oh = w_issue ? w_sel : '0;

  assign w_age_alloc = w_accept ? w_alloc_oh : '0;
  assign w_age_free  = flush ? {NE{1'b1}} : w_issue_oh;

  reservation_station_ooo_age_matrix #(.N(NE)) u_age (
    .clk     (clk),
    .nrst    (nrst),
    .i_alloc (w_age_alloc),
    .i_free  (w_age_free),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  always_comb begin
    w_alloc_oh = '0;
    w_found    = 1'b0;
    for (int e = 0; e < NE; e++) begin
      if (!w_valid[e] && !w_found) begin
        w_alloc_oh[e] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  always_comb begin : p_new
    cdb_hit_t w_hit;
    w_hit        = '0;
    w_new        = '0;
    w_new.valid  = 1'b1;
    w_new.dest   = i_data[IN_W-1 -: RSV_ID_W];
    w_new.opcode = i_data[IN_W-RSV_ID_W-1 -: INSTR_W];
    for (int o = 0; o < N_OPERANDS; o++) begin
      w_new.opnd[o]   = cdb_t'(i_data[o*OP_W +: OP_W]);
      w_hit           = cdb_match(w_new.opnd[o].tag, w_cdb_vld, w_cdb);
      w_new.filled[o] = i_filled[o] | w_hit.hit;
      if (!i_filled[o] && w_hit.hit) w_new.opnd[o].data = w_hit.data;
    end
    for (int o = N_OPERANDS; o < OPS_MAX; o++) w_new.filled[o] = 1'b1;
  end

  always_comb begin : p_next
    cdb_hit_t w_hit;
    w_hit = '0;
    for (int e = 0; e < NE; e++) begin
      w_ent_nxt[e] = r_ent[e];
      for (int o = 0; o < OPS_MAX; o++) begin
        w_hit = cdb_match(r_ent[e].opnd[o].tag, w_cdb_vld, w_cdb);
        if (r_ent[e].valid && !r_ent[e].filled[o] && w_hit.hit) begin
          w_ent_nxt[e].filled[o]    = 1'b1;
          w_ent_nxt[e].opnd[o].data = w_hit.data;
        end
      end
      if (w_issue_oh[e]) w_ent_nxt[e].valid = 1'b0;
      if (w_accept && w_alloc_oh[e]) w_ent_nxt[e] = w_new;
      if (flush) w_ent_nxt[e].valid = 1'b0;
    end
  end

  always_comb begin
    w_sel_dest = '0;
    w_sel_opc  = '0;
    w_sel_ops  = '0;
    w_unused   = 1'b0;
    for (int e = 0; e < NE; e++) begin
      if (w_sel[e]) begin
        w_sel_dest = w_sel_dest | r_ent[e].dest;
        w_sel_opc  = w_sel_opc | r_ent[e].opcode;
        for (int o = 0; o < N_OPERANDS; o++) begin
          w_sel_ops[o*DATA_W +: DATA_W] = w_sel_ops[o*DATA_W +: DATA_W] | r_ent[e].opnd[o].data;
        end
      end
      for (int o = N_OPERANDS; o < OPS_MAX; o++) w_unused = w_unused ^ (^r_ent[e].opnd[o].data);
    end
  end

  assign o_data  = {w_sel_dest, w_sel_opc, w_sel_ops};
  assign o_count = r_count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int e = 0; e < NE; e++) r_ent[e] <= '0;
      r_count   <= '0;
      r_lock    <= 1'b0;
      r_lock_oh <= '0;
    end else begin
      for (int e = 0; e < NE; e++) r_ent[e] <= w_ent_nxt[e];
      r_count   <= flush ? '0 : (r_count + {{N_ENTRIES_W{1'b0}}, w_accept}
                                         - {{N_ENTRIES_W{1'b0}}, w_issue});
      r_lock    <= o_valid & ~o_ready & ~flush;
      r_lock_oh <= w_sel;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reservation_station_ooo.sv
// tb_reservation_station_ooo: drives an out-of-order and an in-order instance against a
// sequence-number based model of the reservation station.
`default_nettype none

module tb_reservation_station_ooo;
  import reservation_station_ooo_pkg::*;

  localparam int NE  = 8;
  localparam int NOP = 2;
  localparam int OPW = RSV_ID_W + DATA_W;
  localparam int IW  = RSV_ID_W + INSTR_W + NOP * OPW;
  localparam int OW  = RSV_ID_W + INSTR_W + NOP * DATA_W;

  logic              clk = 1'b0;
  logic              nrst;
  logic              i_valid, o_ready, flush;
  logic [IW-1:0]     i_data;
  logic [NOP-1:0]    i_filled;
  logic [1:0]        cdb_valid;
  logic [2*CDB_W-1:0] cdb;

  logic              w_iready [2];
  logic              w_ovalid [2];
  logic [OW-1:0]     w_odata  [2];
  logic [3:0]        w_ocount [2];

  always #5 clk = ~clk;

  reservation_station_ooo #(.N_OPERANDS(NOP), .N_ENTRIES_W(3), .N_CDB(2), .IN_ORDER(0)) u_ooo (
    .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_data(i_data), .i_filled(i_filled),
    .i_ready(w_iready[0]), .o_valid(w_ovalid[0]), .o_data(w_odata[0]), .o_ready(o_ready),
    .cdb_valid(cdb_valid), .cdb(cdb), .flush(flush), .o_count(w_ocount[0])
  );

  reservation_station_ooo #(.N_OPERANDS(NOP), .N_ENTRIES_W(3), .N_CDB(2), .IN_ORDER(1)) u_ino (
    .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_data(i_data), .i_filled(i_filled),
    .i_ready(w_iready[1]), .o_valid(w_ovalid[1]), .o_data(w_odata[1]), .o_ready(o_ready),
    .cdb_valid(cdb_valid), .cdb(cdb), .flush(flush), .o_count(w_ocount[1])
  );

  typedef struct packed {
    logic                          v;
    logic [31:0]                   seq;
    logic [RSV_ID_W-1:0]           dest;
    logic [INSTR_W-1:0]            opc;
    logic [NOP-1:0]                f;
    logic [NOP-1:0][RSV_ID_W-1:0]  tag;
    logic [NOP-1:0][DATA_W-1:0]    d;
  } ment_t;

  ment_t mdl [2][NE];
  bit    hold_v [2];
  int    hold_s [2];
  int    seq_ctr;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < NE; s++) mdl[m][s] = '0;
      hold_v[m] = 1'b0;
      hold_s[m] = -1;
    end
    seq_ctr = 0;
  endtask

  function automatic int count_of(input int m);
    int c = 0;
    for (int s = 0; s < NE; s++) if (mdl[m][s].v) c++;
    return c;
  endfunction

  // m=0: oldest ready entry; m=1: oldest valid entry, only if ready. A stalled entry is held.
  function automatic int pick(input int m);
    int best = -1;
    if (hold_v[m]) return hold_s[m];
    for (int s = 0; s < NE; s++) begin
      if (mdl[m][s].v && (m == 1 || (&mdl[m][s].f))) begin
        if (best < 0 || mdl[m][s].seq < mdl[m][best].seq) best = s;
      end
    end
    if (best >= 0 && !(&mdl[m][best].f)) best = -1;
    return best;
  endfunction

  function automatic logic [OW-1:0] exp_data(input int m, input int s);
    return {mdl[m][s].dest, mdl[m][s].opc, mdl[m][s].d[1], mdl[m][s].d[0]};
  endfunction

  task automatic snoop(input logic [RSV_ID_W-1:0] tag, output bit hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int p = 0; p < 2; p++) begin
      if (!hit && cdb_valid[p] && cdb[p*CDB_W + DATA_W +: RSV_ID_W] == tag) begin
        hit = 1'b1;
        d   = cdb[p*CDB_W +: DATA_W];
      end
    end
  endtask

  task automatic model_update(input int m, input int sel);
    int    cnt;
    int    fs;
    bit    hit;
    logic [DATA_W-1:0] hd;
    ment_t ne;
    cnt = count_of(m);
    if (flush) begin
      for (int s = 0; s < NE; s++) mdl[m][s].v = 1'b0;
      hold_v[m] = 1'b0;
      return;
    end
    for (int s = 0; s < NE; s++) begin
      for (int o = 0; o < NOP; o++) begin
        if (mdl[m][s].v && !mdl[m][s].f[o]) begin
          snoop(mdl[m][s].tag[o], hit, hd);
          if (hit) begin
            mdl[m][s].f[o] = 1'b1;
            mdl[m][s].d[o] = hd;
          end
        end
      end
    end
    if (sel >= 0 && o_ready) mdl[m][sel].v = 1'b0;
    hold_v[m] = (sel >= 0) && !o_ready;
    hold_s[m] = sel;
    if (i_valid && cnt < NE) begin
      ne      = '0;
      ne.v    = 1'b1;
      ne.seq  = seq_ctr++;
      ne.dest = i_data[IW-1 -: RSV_ID_W];
      ne.opc  = i_data[IW-RSV_ID_W-1 -: INSTR_W];
      for (int o = 0; o < NOP; o++) begin
        ne.tag[o] = i_data[o*OPW + DATA_W +: RSV_ID_W];
        ne.d[o]   = i_data[o*OPW +: DATA_W];
        ne.f[o]   = i_filled[o];
        if (!i_filled[o]) begin
          snoop(ne.tag[o], hit, hd);
          if (hit) begin
            ne.f[o] = 1'b1;
            ne.d[o] = hd;
          end
        end
      end
      fs = -1;
      for (int s = 0; s < NE; s++) if (!mdl[m][s].v && fs < 0) fs = s;
      mdl[m][fs] = ne;
    end
  endtask

  // Compare this cycle's outputs, advance the model with the driven inputs, then cross the edge.
  task automatic step();
    int sel [2];
    for (int m = 0; m < 2; m++) begin
      sel[m] = pick(m);
      check($sformatf("i_ready[%0d]", m), 64'(w_iready[m]), 64'(count_of(m) < NE));
      check($sformatf("o_valid[%0d]", m), 64'(w_ovalid[m]), 64'(sel[m] >= 0));
      check($sformatf("o_count[%0d]", m), 64'(w_ocount[m]), 64'(count_of(m)));
      if (sel[m] >= 0) check($sformatf("o_data[%0d]", m), 64'(w_odata[m]), 64'(exp_data(m, sel[m])));
    end
    for (int m = 0; m < 2; m++) model_update(m, sel[m]);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [3:0] dest, input logic [7:0] opc,
                        input logic [3:0] t1, input logic [7:0] d1,
                        input logic [3:0] t0, input logic [7:0] d0, input logic [1:0] fl);
    i_valid  = v;
    i_data   = {dest, opc, t1, d1, t0, d0};
    i_filled = fl;
  endtask

  task automatic set_cdb(input logic [1:0] v, input logic [3:0] t1, input logic [7:0] d1,
                         input logic [3:0] t0, input logic [7:0] d0);
    cdb_valid = v;
    cdb       = {t1, d1, t0, d0};
  endtask

  task automatic randomize_inputs();
    set_in($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 8'($urandom),
           4'($urandom_range(0, 7)), 8'($urandom), 4'($urandom_range(0, 7)), 8'($urandom),
           2'($urandom));
    set_cdb({$urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4},
            4'($urandom_range(0, 7)), 8'($urandom), 4'($urandom_range(0, 7)), 8'($urandom));
    o_ready = $urandom_range(0, 9) < 7;
    flush   = $urandom_range(0, 99) < 2;
  endtask

  task automatic check_reset_state(input string tag);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s i_ready[%0d]", tag, m), 64'(w_iready[m]), 64'd1);
      check($sformatf("%s o_valid[%0d]", tag, m), 64'(w_ovalid[m]), 64'd0);
      check($sformatf("%s o_count[%0d]", tag, m), 64'(w_ocount[m]), 64'd0);
      check($sformatf("%s o_data[%0d]", tag, m), 64'(w_odata[m]), 64'd0);
    end
  endtask

  initial begin
    nrst = 1'b0;
    o_ready = 1'b0;
    flush = 1'b0;
    set_in(1'b1, 4'd0, 8'd0, 4'd0, 8'd0, 4'd0, 8'd0, 2'b11);
    set_cdb(2'b00, 4'd0, 8'd0, 4'd0, 8'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    nrst = 1'b1;

    // Two filled entries issue in age order.
    set_in(1'b1, 4'd3, 8'h10, 4'd0, 8'h22, 4'd0, 8'h11, 2'b11);
    step();
    set_in(1'b1, 4'd4, 8'h20, 4'd0, 8'h44, 4'd0, 8'h33, 2'b11);
    step();
    i_valid = 1'b0;
    o_ready = 1'b1;
    check("two_cnt2", 64'(w_ocount[0]), 64'd2);
    check("two_A", 64'(w_odata[0]), 64'h310_2211);
    step();
    check("two_cnt1", 64'(w_ocount[0]), 64'd1);
    check("two_B", 64'(w_odata[1]), 64'h420_4433);
    step();
    check("two_cnt0", 64'(w_ocount[1]), 64'd0);

    // A waits on tag 5, B is filled; CDB port 1 delivers tag 5 later.
    set_in(1'b1, 4'd1, 8'h30, 4'd0, 8'h66, 4'd5, 8'h00, 2'b10);
    step();
    set_in(1'b1, 4'd2, 8'h40, 4'd0, 8'h77, 4'd0, 8'h88, 2'b11);
    step();
    i_valid = 1'b0;
    set_cdb(2'b10, 4'd5, 8'hAA, 4'd0, 8'h00);
    check("wake_ooo_B", 64'(w_odata[0]), 64'h240_7788);
    check("wake_ino_hold", 64'(w_ovalid[1]), 64'd0);
    step();
    set_cdb(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    check("wake_ooo_A", 64'(w_odata[0]), 64'h130_66AA);
    check("wake_ino_A", 64'(w_odata[1]), 64'h130_66AA);
    step();
    check("wake_ino_B", 64'(w_odata[1]), 64'h240_7788);
    step();

    // Same-cycle CDB capture on dispatch.
    o_ready = 1'b0;
    set_in(1'b1, 4'd6, 8'h50, 4'd0, 8'h12, 4'd7, 8'h00, 2'b10);
    set_cdb(2'b01, 4'd0, 8'h00, 4'd7, 8'h55);
    step();
    i_valid = 1'b0;
    set_cdb(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    check("disp_snoop_v", 64'(w_ovalid[0]), 64'd1);
    check("disp_snoop_d", 64'(w_odata[0]), 64'h650_1255);
    o_ready = 1'b1;
    step();

    // Fill to capacity, then issue one while dispatch is held.
    o_ready = 1'b0;
    for (int k = 0; k < NE; k++) begin
      set_in(1'b1, 4'(k + 8), 8'(k), 4'd0, 8'(k * 3), 4'd0, 8'(k * 5), 2'b11);
      step();
    end
    check("full_cnt", 64'(w_ocount[0]), 64'd8);
    check("full_rdy", 64'(w_iready[1]), 64'd0);
    o_ready = 1'b1;
    step();
    check("free_cnt", 64'(w_ocount[0]), 64'd7);
    o_ready = 1'b0;
    step();
    check("refill_cnt", 64'(w_ocount[1]), 64'd8);
    i_valid = 1'b0;
    o_ready = 1'b1;
    repeat (NE) step();

    // Six entries, then flush colliding with a dispatch and a CDB match.
    o_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_in(1'b1, 4'(k), 8'hC0, 4'd0, 8'(k), 4'd0, 8'(k + 1), 2'b11);
      step();
    end
    check("pre_flush_cnt", 64'(w_ocount[0]), 64'd6);
    flush = 1'b1;
    set_in(1'b1, 4'd9, 8'hEE, 4'd0, 8'h01, 4'd9, 8'h00, 2'b10);
    set_cdb(2'b01, 4'd0, 8'h00, 4'd9, 8'h99);
    step();
    flush = 1'b0;
    i_valid = 1'b0;
    set_cdb(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    check("flush_cnt", 64'(w_ocount[0]), 64'd0);
    check("flush_vld", 64'(w_ovalid[1]), 64'd0);
    step();

    for (int c = 0; c < 1500; c++) begin
      randomize_inputs();
      step();
    end

    // Asynchronous reset in the middle of traffic.
    flush = 1'b0;
    o_ready = 1'b0;
    i_valid = 1'b1;
    #2;
    nrst = 1'b0;
    #1;
    check_reset_state("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    nrst = 1'b1;

    for (int c = 0; c < 1000; c++) begin
      randomize_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
